debounce_sync: RTL and testbench

//  Input conditioning stage upstream of the lab register (DFF) blocks: takes an async/bouncy
//  1-bit input, synchronises it into clk, debounces it, and yields a clean level q that

---
 rtl/debounce_sync_pkg.sv | 9 +
 rtl/debounce_sync_sync_chain.sv | 24 ++
 rtl/debounce_sync.sv | 80 ++++++++
 tb/tb_debounce_sync.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
// Shared types for the debounce_sync input-conditioning block.
package debounce_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Asynchronous-reset flop chain that brings an asynchronous input into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
        end
    end

    assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise, debounce and edge-detect a bouncy 1-bit input; counts committed rising edges.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_raw,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    db_state_e     state;
    logic [CW-1:0] cnt;
    logic          s_out;
    logic          differ;
    logic          commit;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_raw),
        .q   (s_out)
    );

    // A candidate change is only qualified while enabled; the counter holds samples seen so far.
    assign differ = en && (s_out != q);
    assign commit = differ && ((state == IDLE) ? (DB_CYCLES == 1) : (cnt == CNT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (commit) begin
                q     <= s_out;
                rise  <= s_out;
                fall  <= ~s_out;
                state <= IDLE;
                cnt   <= '0;
            end else if (differ) begin
                state <= PEND;
                cnt   <= cnt + CW'(1);
            end else begin
                // Bounce back to q, or enable dropped: discard the pending change.
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end

    assign busy = (state == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (clr_cnt) begin
            edge_cnt <= '0;
        end else if (commit && s_out) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: reset, latency, bounce rejection, enable gating, counter wrap.
module tb_debounce_sync;

    logic       clk, rst, d_raw, en, clr_cnt;
    logic       q, rise, fall, busy;
    logic [7:0] edge_cnt;
    logic       d2, clr2;
    logic       q2, rise2, fall2, busy2;
    logic [1:0] edge_cnt2;
    logic       syn_q;
    logic       seen_rise, seen_fall, seen_syn;
    int         total = 0;
    int         bad   = 0;

    debounce_sync dut (
        .clk(clk), .rst(rst), .d_raw(d_raw), .en(en), .clr_cnt(clr_cnt),
        .q(q), .rise(rise), .fall(fall), .busy(busy), .edge_cnt(edge_cnt)
    );

    debounce_sync #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .d_raw(d2), .en(en), .clr_cnt(clr2),
        .q(q2), .rise(rise2), .fall(fall2), .busy(busy2), .edge_cnt(edge_cnt2)
    );

    // Downstream register fed by the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) syn_q <= 1'b0;
        else     syn_q <= q;
    end

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen_rise = seen_rise | rise;
            seen_fall = seen_fall | fall;
            seen_syn  = seen_syn | syn_q;
        end
    endtask

    task automatic clear_seen();
        seen_rise = 1'b0;
        seen_fall = 1'b0;
        seen_syn  = 1'b0;
    endtask

    logic [1:0] exp_cnt2 [4];

    initial begin
        exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b0; d_raw = 1'b0; en = 1'b1; clr_cnt = 1'b0; d2 = 1'b0; clr2 = 1'b0;
        clear_seen();

        // 1: reset asserted mid-cycle for 30 ns with d_raw already high
        #5  rst = 1'b1; d_raw = 1'b1;
        #10 chk("rst_q", q, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", edge_cnt, 0);
        #20 chk("rst_q_late", q, 0);
        chk("rst_q2", q2, 0);
        rst = 1'b0;
        @(negedge clk);
        tick(2); chk("rel_busy_e2", busy, 0);
        tick(1); chk("rel_busy_e3", busy, 1);
        tick(2); chk("rel_q_e5", q, 0);
        tick(1); chk("rel_q_e6", q, 1);
        chk("rel_rise_e6", rise, 1);
        chk("rel_fall_e6", fall, 0);
        chk("rel_cnt_e6", edge_cnt, 1);
        chk("syn_e6", syn_q, 0);
        tick(1); chk("rel_rise_e7", rise, 0);
        chk("syn_e7", syn_q, 1);

        // clean fall
        d_raw = 1'b0;
        tick(5); chk("fall_q_e5", q, 1);
        tick(1); chk("fall_q_e6", q, 0);
        chk("fall_pulse", fall, 1);
        chk("fall_norise", rise, 0);
        chk("fall_cnt", edge_cnt, 1);
        tick(1); chk("fall_pulse_e7", fall, 0);

        // 2: clean 0->1 step
        d_raw = 1'b1;
        tick(2); chk("step_busy_e2", busy, 0);
        tick(1); chk("step_busy_e3", busy, 1);
        tick(2); chk("step_q_e5", q, 0);
        tick(1); chk("step_q_e6", q, 1);
        chk("step_rise_e6", rise, 1);
        chk("step_cnt", edge_cnt, 2);
        tick(1); chk("step_rise_e7", rise, 0);
        d_raw = 1'b0;
        tick(9); chk("step_back_q", q, 0);

        // 3: two-cycle bounce must be rejected
        clear_seen();
        d_raw = 1'b1;
        tick(2); d_raw = 1'b0;
        tick(1); chk("bnc_busy", busy, 1);
        tick(6);
        chk("bnc_q", q, 0);
        chk("bnc_busy_end", busy, 0);
        chk("bnc_norise", seen_rise, 0);
        chk("bnc_cnt", edge_cnt, 2);
        chk("bnc_syn", seen_syn, 0);

        // 4: enable gating
        clear_seen();
        en = 1'b0; d_raw = 1'b1;
        tick(6);
        chk("en0_q", q, 0);
        chk("en0_busy", busy, 0);
        chk("en0_norise", seen_rise, 0);
        en = 1'b1;
        tick(3); chk("en1_q_e3", q, 0);
        tick(1); chk("en1_q_e4", q, 1);
        chk("en1_rise", rise, 1);
        chk("en1_cnt", edge_cnt, 3);
        clear_seen();
        d_raw = 1'b0;
        tick(3); chk("en_mid_busy", busy, 1);
        en = 1'b0;
        tick(1); chk("en_drop_busy", busy, 0);
        tick(6);
        chk("en_drop_q", q, 1);
        chk("en_drop_nofall", seen_fall, 0);
        en = 1'b1;
        tick(3); chk("en_re_q_e3", q, 1);
        tick(1); chk("en_re_q_e4", q, 0);
        chk("en_re_fall", fall, 1);

        // 5: 2-bit edge counter wrap and clear priority
        for (int k = 0; k < 4; k++) begin
            d2 = 1'b1;
            tick(6);
            chk("wrap_rise", rise2, 1);
            chk("wrap_cnt", edge_cnt2, exp_cnt2[k]);
            d2 = 1'b0;
            tick(7);
            chk("wrap_q_low", q2, 0);
        end
        d2 = 1'b1;
        tick(5); clr2 = 1'b1;
        tick(1);
        chk("clr_rise", rise2, 1);
        chk("clr_wins", edge_cnt2, 0);
        clr2 = 1'b0;

        // synchronous clear on the default instance
        clr_cnt = 1'b1;
        tick(1); clr_cnt = 1'b0;
        chk("clr_cnt", edge_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
